// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_pkg: shared types and constants for the hazard/stall controller.
// Control bundle layout and NOP-control encodings live here.
package hazard_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int PERF_CNT_W = 16;
    localparam int CNT_W      = 4;

    typedef logic [0:0] state_t;
    localparam state_t RUN     = 1'b0;
    localparam state_t MULBUSY = 1'b1;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic ifid_flush;
        logic idex_bubble;
        logic em_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_DEFAULT  = hz_ctrl_t'(6'b111_000);
    localparam hz_ctrl_t CTRL_LOAD_USE = hz_ctrl_t'(6'b001_010);
    localparam hz_ctrl_t CTRL_MUL      = hz_ctrl_t'(6'b000_001);
    localparam hz_ctrl_t CTRL_FLUSH    = hz_ctrl_t'(6'b111_110);
    localparam hz_ctrl_t CTRL_RESET    = hz_ctrl_t'(6'b000_111);

    function automatic logic load_use_hit(
        input logic                  mem_read,
        input logic [REG_ADDR_W-1:0] wr_reg,
        input logic                  use1,
        input logic [REG_ADDR_W-1:0] rd1,
        input logic                  use2,
        input logic [REG_ADDR_W-1:0] rd2
    );
        return mem_read && (wr_reg != '0) &&
               ((use1 && rd1 == wr_reg) || (use2 && rd2 == wr_reg));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline-side hazard inputs and control outputs.
// master = pipeline datapath, slave = hazard controller.
interface hazard_stall_ctrl_if;
    import hazard_pkg::*;

    logic [REG_ADDR_W-1:0] IDreadReg1;
    logic [REG_ADDR_W-1:0] IDreadReg2;
    logic                  IDusesReg1;
    logic                  IDusesReg2;
    logic                  IEMemRead;
    logic [REG_ADDR_W-1:0] IEwriteReg;
    logic                  IEmulOp;
    logic                  IEbranchTaken;
    logic                  PCWrite;
    logic                  IFIDWrite;
    logic                  IDEXWrite;
    logic                  IFIDFlush;
    logic                  IDEXBubble;
    logic                  EMBubble;
    logic                  stallActive;
    logic [PERF_CNT_W-1:0] stallCycles;
    logic [PERF_CNT_W-1:0] flushCount;

    modport master (
        output IDreadReg1, IDreadReg2, IDusesReg1, IDusesReg2,
        output IEMemRead, IEwriteReg, IEmulOp, IEbranchTaken,
        input  PCWrite, IFIDWrite, IDEXWrite,
        input  IFIDFlush, IDEXBubble, EMBubble,
        input  stallActive, stallCycles, flushCount
    );

    modport slave (
        input  IDreadReg1, IDreadReg2, IDusesReg1, IDusesReg2,
        input  IEMemRead, IEwriteReg, IEmulOp, IEbranchTaken,
        output PCWrite, IFIDWrite, IDEXWrite,
        output IFIDFlush, IDEXBubble, EMBubble,
        output stallActive, stallCycles, flushCount
    );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones until reset.
// Used for the optional hazard performance counters.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // next count: step on inc unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc && count_q != '1) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // count register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall, multi-cycle EX hold, branch flush.
// Optional perf counters built only with HAZARD_PERF_CNT_EN defined.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input logic                clk,
    input logic                rst_n,
    hazard_stall_ctrl_if.slave hz
);

    localparam bit MUL_EN = (MUL_LATENCY > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        MUL_EN ? CNT_W'(MUL_LATENCY - 2) : '0;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    hz_ctrl_t         ctrl;
    logic             lu_hit;
    logic             stall_active;
    logic [PERF_CNT_W-1:0] stall_cnt;
    logic [PERF_CNT_W-1:0] flush_cnt;

    assign lu_hit = load_use_hit(hz.IEMemRead, hz.IEwriteReg,
                                 hz.IDusesReg1, hz.IDreadReg1,
                                 hz.IDusesReg2, hz.IDreadReg2);

    // hazard priority: mul, then branch flush, then load-use
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl    = CTRL_DEFAULT;
        unique case (state_q)
            RUN: begin
                if (hz.IEmulOp && MUL_EN) begin
                    ctrl    = CTRL_MUL;
                    cnt_d   = CNT_LOAD;
                    state_d = MULBUSY;
                end else if (hz.IEbranchTaken) begin
                    ctrl = CTRL_FLUSH;
                end else if (lu_hit) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end
            MULBUSY: begin
                if (cnt_q != '0) begin
                    ctrl  = CTRL_MUL;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RUN;
                    if (lu_hit) begin
                        ctrl = CTRL_LOAD_USE;
                    end
                end
            end
        endcase
        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end
    end

    // FSM state and mul countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_active = rst_n & ~ctrl.pc_write;

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_active),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl.ifid_flush & rst_n),
        .count (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    assign hz.PCWrite     = ctrl.pc_write;
    assign hz.IFIDWrite   = ctrl.ifid_write;
    assign hz.IDEXWrite   = ctrl.idex_write;
    assign hz.IFIDFlush   = ctrl.ifid_flush;
    assign hz.IDEXBubble  = ctrl.idex_bubble;
    assign hz.EMBubble    = ctrl.em_bubble;
    assign hz.stallActive = stall_active;
    assign hz.stallCycles = stall_cnt;
    assign hz.flushCount  = flush_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed scoreboard bench for hazard_stall_ctrl.
// Expectations follow HAZARD_PERF_CNT_EN if defined for the build.
module tb_hazard_stall_ctrl;

    // {PCWrite,IFIDWrite,IDEXWrite,IFIDFlush,IDEXBubble,EMBubble,stallActive}
    localparam logic [6:0] E_DEF = 7'b111_000_0;
    localparam logic [6:0] E_LU  = 7'b001_010_1;
    localparam logic [6:0] E_MUL = 7'b000_001_1;
    localparam logic [6:0] E_BR  = 7'b111_110_0;
    localparam logic [6:0] E_RST = 7'b000_111_0;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [6:0] ctl;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_stall;
    int   exp_flush;
    exp_t sb[$];

    hazard_stall_ctrl_if hz4 ();
    hazard_stall_ctrl_if hz16 ();

    hazard_stall_ctrl #(.MUL_LATENCY(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz4)
    );

    hazard_stall_ctrl #(.MUL_LATENCY(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        assert (!(hz4.IEmulOp && hz4.IEbranchTaken)) else begin
            errors++;
            $error("FAIL illegal_mul_branch obs=1 exp=0");
        end
    end

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic idle4();
        hz4.IDreadReg1    = '0;
        hz4.IDreadReg2    = '0;
        hz4.IDusesReg1    = 1'b0;
        hz4.IDusesReg2    = 1'b0;
        hz4.IEMemRead     = 1'b0;
        hz4.IEwriteReg    = '0;
        hz4.IEmulOp       = 1'b0;
        hz4.IEbranchTaken = 1'b0;
    endtask

    task automatic ld(logic [3:0] wr, logic u1, logic [3:0] r1,
                      logic u2, logic [3:0] r2);
        hz4.IEMemRead  = 1'b1;
        hz4.IEwriteReg = wr;
        hz4.IDusesReg1 = u1;
        hz4.IDreadReg1 = r1;
        hz4.IDusesReg2 = u2;
        hz4.IDreadReg2 = r2;
    endtask

    // push expectation, compare mid-cycle, then advance one clock
    task automatic step(string tag, logic [6:0] e);
        exp_t x;
        logic [6:0] obs;
        sb.push_back('{tag, e});
        #3;
        obs = {hz4.PCWrite, hz4.IFIDWrite, hz4.IDEXWrite,
               hz4.IFIDFlush, hz4.IDEXBubble, hz4.EMBubble,
               hz4.stallActive};
        x = sb.pop_front();
        check(x.tag, 16'(obs), 16'(x.ctl));
        if (rst_n) begin
            if (x.ctl[0] && exp_stall < 65535) exp_stall++;
            if (x.ctl[3] && exp_flush < 65535) exp_flush++;
        end else begin
            exp_stall = 0;
            exp_flush = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(string tag);
        check({tag, "_stall"}, hz4.stallCycles,
              PERF ? 16'(exp_stall) : 16'h0);
        check({tag, "_flush"}, hz4.flushCount,
              PERF ? 16'(exp_flush) : 16'h0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_stall = 0;
        exp_flush = 0;
        rst_n     = 1'b0;
        idle4();
        hz16.IDreadReg1    = '0;
        hz16.IDreadReg2    = '0;
        hz16.IDusesReg1    = 1'b0;
        hz16.IDusesReg2    = 1'b0;
        hz16.IEMemRead     = 1'b0;
        hz16.IEwriteReg    = '0;
        hz16.IEmulOp       = 1'b0;
        hz16.IEbranchTaken = 1'b0;
        #1;

        step("reset_out", E_RST);
        chk_cnt("reset");
        rst_n = 1'b1;
        step("idle", E_DEF);

        ld(4'd5, 1'b0, 4'd0, 1'b1, 4'd5);
        step("lu_reg2", E_LU);
        idle4();
        step("lu_bubble", E_DEF);
        ld(4'd0, 1'b0, 4'd0, 1'b1, 4'd0);
        step("lu_x0", E_DEF);
        ld(4'd7, 1'b1, 4'd7, 1'b0, 4'd0);
        step("lu_reg1", E_LU);
        ld(4'd7, 1'b0, 4'd7, 1'b0, 4'd7);
        step("lu_unused", E_DEF);
        idle4();

        ld(4'd5, 1'b0, 4'd0, 1'b1, 4'd5);
        hz4.IEbranchTaken = 1'b1;
        step("br_over_lu", E_BR);
        idle4();
        chk_cnt("branch");

        hz4.IEmulOp = 1'b1;
        step("mul_c1", E_MUL);
        step("mul_c2", E_MUL);
        step("mul_c3", E_MUL);
        step("mul_leave", E_DEF);
        step("mul_b2b", E_MUL);
        hz4.IEmulOp       = 1'b0;
        hz4.IEbranchTaken = 1'b1;
        step("mul_br_ign", E_MUL);
        hz4.IEbranchTaken = 1'b0;
        step("mul_c3b", E_MUL);
        ld(4'd3, 1'b1, 4'd3, 1'b0, 4'd0);
        step("mul_end_lu", E_LU);
        idle4();
        step("mul_run", E_DEF);
        chk_cnt("mul");

        hz4.IEmulOp = 1'b1;
        step("rmul_c1", E_MUL);
        hz4.IEmulOp = 1'b0;
        step("rmul_c2", E_MUL);
        rst_n = 1'b0;
        step("rmul_rst", E_RST);
        chk_cnt("rmul_rst");
        rst_n = 1'b1;
        step("rmul_rel", E_DEF);
        chk_cnt("rmul_rel");
        hz4.IEmulOp = 1'b1;
        step("rmul2_c1", E_MUL);
        hz4.IEmulOp = 1'b0;
        step("rmul2_c2", E_MUL);
        step("rmul2_c3", E_MUL);
        step("rmul2_end", E_DEF);
        chk_cnt("rmul2");

        check("sat_start", hz16.stallCycles, 16'h0);
        hz16.IEmulOp = 1'b1;
        repeat (1600) @(posedge clk);
        #1;
        check("sat_mid", hz16.stallCycles,
              PERF ? 16'd1500 : 16'h0);
        repeat (68400) @(posedge clk);
        #1;
        check("sat_end", hz16.stallCycles,
              PERF ? 16'hFFFF : 16'h0);
        check("sat_flush", hz16.flushCount, 16'h0);
        hz16.IEmulOp = 1'b0;

        check("sb_empty", 16'(sb.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage datapath, sitting beside the forwarding unit. It drives the PC and pipeline-register write enables, the flushes and the bubble inserts. It resolves three hazards: load-use (one-cycle stall), multi-cycle EX operations (EX held for a fixed latency via an internal countdown FSM), and taken branches (flush of wrong-path instructions). Forwarding is handled elsewhere; this block only stalls, flushes or bubbles.

## Interface
- MUL_LATENCY, 4, total cycles a multi-cycle op occupies EX; legal 1..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- IDreadReg1, IDreadReg2  in  4 each  source registers of the instruction in ID.
- IDusesReg1, IDusesReg2  in  1 each  the matching ID source register is actually read.
- IEMemRead  in  1  the instruction in EX is a load.
- IEwriteReg  in  4  destination register of the instruction in EX.
- IEmulOp  in  1  the instruction in EX is multi-cycle.
- IEbranchTaken  in  1  the branch in EX resolved taken.
- PCWrite, IFIDWrite, IDEXWrite  out  1 each  PC / IF-ID / ID-EX write enables.
- IFIDFlush  out  1  load a NOP into IF/ID.
- IDEXBubble  out  1  load a NOP into ID/EX.
- EMBubble  out  1  load a NOP into EX/MEM.
- stallActive  out  1  any stall asserted this cycle.
- stallCycles, flushCount  out  16 each  performance counters; see Configuration.

## Operation
- FSM states:
  - RUN: normal operation.
  - MULBUSY: a multi-cycle op is holding EX.
- 4-bit down-counter `cnt`.
- Default outputs: PCWrite=IFIDWrite=IDEXWrite=1; IFIDFlush=IDEXBubble=EMBubble=0.
- Load-use hazard condition: IEMemRead && IEwriteReg!=0 && ((IDusesReg1 && IDreadReg1==IEwriteReg) || (IDusesReg2 && IDreadReg2==IEwriteReg)).
- RUN, evaluated in priority order:
  1. IEmulOp && MUL_LATENCY>1: mul stall. Outputs PCWrite=IFIDWrite=IDEXWrite=0, EMBubble=1. Load cnt=MUL_LATENCY-2. Next state MULBUSY.
  2. IEbranchTaken: flush. Outputs IFIDFlush=1, IDEXBubble=1, PCWrite=1. Stay in RUN.
  3. Load-use hazard: stall. Outputs PCWrite=IFIDWrite=0, IDEXBubble=1, IDEXWrite=1. Stay in RUN.
- MULBUSY:
  - cnt!=0: mul stall outputs as above; decrement cnt.
  - cnt==0: default outputs, except the load-use rule still applies. Next state RUN.
  - IEmulOp and IEbranchTaken are ignored in MULBUSY, so the held op cannot retrigger.
- IEmulOp && IEbranchTaken together is illegal. The mul rule wins; the bench asserts this never occurs.
- Load-use and mul cannot coincide, since a load is not a multi-cycle op.
- Load-use and branch together: the branch wins, because the stalled instruction is on the wrong path.
- stallActive = (PCWrite==0).

## Timing
- Asynchronous reset: state RUN, cnt=0, counters 0.
- While rst_n=0, outputs are forced: PCWrite=IFIDWrite=IDEXWrite=0, IFIDFlush=IDEXBubble=EMBubble=1, stallActive=0.
- All hazard outputs are combinational from the current state and inputs, valid in the same cycle. State and counters update on the rising edge.
- Load-use stall: exactly 1 cycle per hazard. On the next cycle EX holds the bubble, so the condition clears.
- Multi-cycle op: MUL_LATENCY-1 stall cycles. The op leaves EX on its MUL_LATENCY-th cycle.
- MUL_LATENCY=1: the FSM never leaves RUN and no stall is generated.
- Back-to-back multi-cycle ops: the second triggers in the RUN cycle immediately after the first leaves EX.
- Reset during MULBUSY returns the FSM to RUN immediately and clears cnt.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stallCycles increments on every cycle with stallActive=1.
  - flushCount increments on every cycle with IFIDFlush=1 while rst_n=1.
  - Both counters are 16-bit, saturate at 16'hFFFF, and are cleared only by reset.
- HAZARD_PERF_CNT_EN undefined: both ports remain and are tied to 16'h0000; no counter flops are built.

## Structure
- Package hazard_pkg:
  - state typedef: RUN=1'b0, MULBUSY=1'b1.
  - REG_ADDR_W=4, PERF_CNT_W=16.
  - NOP-control constants.
- Sub-module sat_counter (parameter width; inputs clk, rst_n, inc; output count). Two instances, present only under HAZARD_PERF_CNT_EN.

## Test plan
- Load-use, IEMemRead=1, IEwriteReg=5, IDreadReg2=5, IDusesReg2=1 -> one cycle of PCWrite=0, IFIDWrite=0, IDEXBubble=1, then default outputs. Repeat with IEwriteReg=0 -> no stall.
- Mul op, MUL_LATENCY=4, IEmulOp=1 held -> PCWrite=0 and EMBubble=1 for 3 cycles, then 1 default cycle; the op is not retriggered.
- IEbranchTaken=1 together with a load-use match -> IFIDFlush=1, IDEXBubble=1, PCWrite=1, no stall. flushCount increments by 1 with the macro defined.
- rst_n pulsed low during the 2nd MULBUSY cycle -> forced reset outputs immediately. After release, state is RUN and stallCycles=0.
- 70000 consecutive mul-stall cycles with the macro defined -> stallCycles saturates at 65535. With the macro undefined -> stallCycles reads 0.
